// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mc_ctrl
// Brief   : Multi-cycle MIPS-subset control FSM with memory timeout, fault
//           flags and retired-instruction counter.
// Revision: 1.0
// ============================================================================
module mc_ctrl #(
  parameter int ALU_W = 4,
  parameter int TMO_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             ovf,
  input  logic             mem_ready,
  output logic             PcWrite,
  output logic             IrWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             AluSrc,
  output logic [1:0]       RegDst,
  output logic [1:0]       wd_sel,
  output logic [2:0]       NpcSel,
  output logic [1:0]       ExtOp,
  output logic [ALU_W-1:0] AluCtrl,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic             ovf_trap,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_SLT, I_JR, I_ORI, I_LUI, I_LW, I_SW,
    I_ADDI, I_ADDIU, I_BEQ, I_J, I_JAL, I_ILL
  } instr_t;

  localparam logic [2:0] c_ALU_ADDU = 3'd0;
  localparam logic [2:0] c_ALU_SUBU = 3'd1;
  localparam logic [2:0] c_ALU_OR   = 3'd2;
  localparam logic [2:0] c_ALU_BB   = 3'd3;
  localparam logic [2:0] c_ALU_AA   = 3'd4;
  localparam logic [2:0] c_ALU_ADD  = 3'd5;
  localparam logic [2:0] c_ALU_LT   = 3'd6;

  state_t            r_state;
  state_t            w_nextState;
  logic [TMO_W-1:0]  r_tmo;
  logic [TMO_W-1:0]  w_tmoNext;
  logic [CNT_W-1:0]  r_instret;
  logic              r_illegal;
  logic              r_busErr;

  instr_t            w_instr;
  logic              w_isRType;
  logic              w_pcWrite;
  logic              w_irWrite;
  logic              w_regWrite;
  logic              w_memWrite;
  logic              w_memRead;
  logic              w_aluSrc;
  logic [1:0]        w_regDst;
  logic [1:0]        w_wdSel;
  logic [2:0]        w_npcSel;
  logic [1:0]        w_extOp;
  logic [2:0]        w_aluCode;
  logic              w_ovfTrap;
  logic              w_tmoInc;
  logic              w_setIllegal;
  logic              w_setBusErr;

  // Instruction classification from the held IR fields
  always_comb begin
    w_instr   = I_ILL;
    w_isRType = 1'b0;
    case (opcode)
      6'b000000: begin
        w_isRType = 1'b1;
        case (funct)
          6'b100001: w_instr = I_ADDU;
          6'b100011: w_instr = I_SUBU;
          6'b101010: w_instr = I_SLT;
          6'b001000: w_instr = I_JR;
          default:   w_instr = I_ILL;
        endcase
      end
      6'b001101: w_instr = I_ORI;
      6'b001111: w_instr = I_LUI;
      6'b100011: w_instr = I_LW;
      6'b101011: w_instr = I_SW;
      6'b001000: w_instr = I_ADDI;
      6'b001001: w_instr = I_ADDIU;
      6'b000100: w_instr = I_BEQ;
      6'b000010: w_instr = I_J;
      6'b000011: w_instr = I_JAL;
      default:   w_instr = I_ILL;
    endcase
  end

  assign w_tmoNext = r_tmo + TMO_W'(1);

  always_comb begin
    w_nextState  = r_state;
    w_pcWrite    = 1'b0;
    w_irWrite    = 1'b0;
    w_regWrite   = 1'b0;
    w_memWrite   = 1'b0;
    w_memRead    = 1'b0;
    w_aluSrc     = 1'b0;
    w_regDst     = 2'b00;
    w_wdSel      = 2'b00;
    w_npcSel     = 3'b000;
    w_extOp      = 2'b00;
    w_aluCode    = c_ALU_ADDU;
    w_ovfTrap    = 1'b0;
    w_tmoInc     = 1'b0;
    w_setIllegal = 1'b0;
    w_setBusErr  = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_memRead = 1'b1;
        if (mem_ready) begin
          w_irWrite   = 1'b1;
          w_nextState = S_DECODE;
        end
      end

      S_DECODE: begin
        if (w_instr == I_ILL) begin
          w_setIllegal = 1'b1;
          w_nextState  = S_HALT;
        end else begin
          w_nextState  = S_EXEC;
        end
      end

      S_EXEC: begin
        w_nextState = S_WB;
        case (w_instr)
          I_ADDU:  w_aluCode = c_ALU_ADDU;
          I_SUBU:  w_aluCode = c_ALU_SUBU;
          I_SLT:   w_aluCode = c_ALU_LT;
          I_ORI:   begin w_aluCode = c_ALU_OR;   w_aluSrc = 1'b1; end
          I_LUI:   begin w_aluCode = c_ALU_BB;   w_aluSrc = 1'b1; w_extOp = 2'b10; end
          I_ADDI:  begin w_aluCode = c_ALU_ADD;  w_aluSrc = 1'b1; w_extOp = 2'b01; end
          I_ADDIU: begin w_aluCode = c_ALU_ADDU; w_aluSrc = 1'b1; w_extOp = 2'b01; end
          I_LW, I_SW: begin
            w_aluSrc    = 1'b1;
            w_extOp     = 2'b01;
            w_nextState = S_MEM;
          end
          I_BEQ: begin
            w_aluCode   = c_ALU_SUBU;
            w_extOp     = 2'b01;
            w_pcWrite   = 1'b1;
            w_npcSel    = zero ? 3'b001 : 3'b000;
            w_nextState = S_FETCH;
          end
          I_J: begin
            w_pcWrite   = 1'b1;
            w_npcSel    = 3'b011;
            w_nextState = S_FETCH;
          end
          I_JR: begin
            w_aluCode   = c_ALU_AA;
            w_pcWrite   = 1'b1;
            w_npcSel    = 3'b100;
            w_nextState = S_FETCH;
          end
          I_JAL: begin
            w_pcWrite   = 1'b1;
            w_npcSel    = 3'b010;
            w_regWrite  = 1'b1;
            w_regDst    = 2'b10;
            w_wdSel     = 2'b10;
            w_nextState = S_FETCH;
          end
          default: w_nextState = S_HALT;
        endcase
      end

      S_MEM: begin
        w_aluCode  = c_ALU_ADDU;
        w_memRead  = (w_instr == I_LW);
        w_memWrite = (w_instr == I_SW);
        if (mem_ready) begin
          if (w_instr == I_SW) begin
            w_pcWrite   = 1'b1;
            w_nextState = S_FETCH;
          end else begin
            w_nextState = S_WB;
          end
        end else if (w_tmoNext == {TMO_W{1'b1}}) begin
          // Counter reaches all-ones on this wait cycle: give up on the bus
          w_setBusErr = 1'b1;
          w_nextState = S_HALT;
        end else begin
          w_tmoInc = 1'b1;
        end
      end

      S_WB: begin
        w_pcWrite   = 1'b1;
        w_nextState = S_FETCH;
        w_ovfTrap   = (w_instr == I_ADDI) && ovf;
        w_regWrite  = !w_ovfTrap;
        w_regDst    = w_isRType ? 2'b01 : 2'b00;
        w_wdSel     = (w_instr == I_LW) ? 2'b01 : 2'b00;
      end

      S_HALT: w_nextState = S_HALT;

      default: w_nextState = S_HALT;
    endcase
  end

  // Write strobes are suppressed for the whole time reset is held
  assign PcWrite  = w_pcWrite  & rst;
  assign IrWrite  = w_irWrite  & rst;
  assign RegWrite = w_regWrite & rst;
  assign MemWrite = w_memWrite & rst;
  assign MemRead  = w_memRead;
  assign AluSrc   = w_aluSrc;
  assign RegDst   = w_regDst;
  assign wd_sel   = w_wdSel;
  assign NpcSel   = w_npcSel;
  assign ExtOp    = w_extOp;
  assign AluCtrl  = ALU_W'(w_aluCode);
  assign ovf_trap = w_ovfTrap;
  assign state    = r_state;
  assign illegal  = r_illegal;
  assign bus_err  = r_busErr;
  assign instret  = r_instret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_tmo     <= '0;
      r_instret <= '0;
      r_illegal <= 1'b0;
      r_busErr  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState == S_MEM && r_state != S_MEM) begin
        r_tmo <= '0;
      end else if (w_tmoInc) begin
        r_tmo <= w_tmoNext;
      end
      if (PcWrite) begin
        r_instret <= r_instret + CNT_W'(1);
      end
      if (w_setIllegal) begin
        r_illegal <= 1'b1;
      end
      if (w_setBusErr) begin
        r_busErr <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mc_ctrl
// Brief   : Directed bench; expected per-cycle traces are expanded from each
//           instruction's documented behaviour and compared every cycle.
// Revision: 1.0
// ============================================================================
module tb_mc_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        ovf;
  logic        mem_ready;
  logic        PcWrite, IrWrite, RegWrite, MemWrite, MemRead, AluSrc;
  logic [1:0]  RegDst, wd_sel, ExtOp;
  logic [2:0]  NpcSel, state;
  logic [3:0]  AluCtrl;
  logic        illegal, bus_err, ovf_trap;
  logic [31:0] instret;

  mc_ctrl #(.ALU_W(4), .TMO_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .ovf(ovf), .mem_ready(mem_ready), .PcWrite(PcWrite), .IrWrite(IrWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .AluSrc(AluSrc), .RegDst(RegDst), .wd_sel(wd_sel), .NpcSel(NpcSel),
    .ExtOp(ExtOp), .AluCtrl(AluCtrl), .state(state), .illegal(illegal),
    .bus_err(bus_err), .ovf_trap(ovf_trap), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, rw, mw, mr, asrc;
    logic [1:0] rdst, wd;
    logic [2:0] npc;
    logic [1:0] ext;
    logic [3:0] alu;
    logic       trap, ill, berr;
  } obs_t;

  localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_JR = 3, K_ORI = 4,
                 K_LUI = 5, K_LW = 6, K_SW = 7, K_ADDI = 8, K_ADDIU = 9,
                 K_BEQ = 10, K_J = 11, K_JAL = 12, K_ILL = 13;

  int          tests;
  int          fails;
  logic        mIll;
  logic        mBerr;
  logic [31:0] mInstret;

  function automatic int kindOf(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: case (fn)
        6'b100001: return K_ADDU;
        6'b100011: return K_SUBU;
        6'b101010: return K_SLT;
        6'b001000: return K_JR;
        default:   return K_ILL;
      endcase
      6'b001101: return K_ORI;
      6'b001111: return K_LUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b001000: return K_ADDI;
      6'b001001: return K_ADDIU;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic obs_t base(input logic [2:0] s);
    obs_t e;
    e      = '0;
    e.st   = s;
    e.ill  = mIll;
    e.berr = mBerr;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: compare all outputs mid-cycle, then advance past the edge
  task automatic step(input obs_t e);
    obs_t a;
    @(negedge clk);
    a = {state, PcWrite, IrWrite, RegWrite, MemWrite, MemRead, AluSrc,
         RegDst, wd_sel, NpcSel, ExtOp, AluCtrl, ovf_trap, illegal, bus_err};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL cycle@%0t op=%b fn=%b: got %h expected %h", $time, opcode, funct, a, e);
    end
    chk("instret", 64'(instret), 64'(mInstret));
    if (e.pcw) mInstret = mInstret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    obs_t e;
    rst       = 1'b0;
    mem_ready = 1'b1;
    #1;
    mIll     = 1'b0;
    mBerr    = 1'b0;
    mInstret = '0;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_bus_err", 64'(bus_err), 64'd0);
    e    = base(3'd0);
    e.mr = 1'b1;
    step(e);
    step(e);
    rst       = 1'b1;
    mem_ready = 1'b0;
  endtask

  // Expand one instruction into its expected cycle trace.
  // memNever: memory never answers; abortAt>=0 leaves MEM early for a reset.
  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input logic o, input int fetchWait,
                          input int memWait, input bit memNever, input int abortAt);
    obs_t e;
    int   k;
    opcode = op; funct = fn; zero = z; ovf = o;
    k = kindOf(op, fn);
    for (int i = 0; i < fetchWait; i++) begin
      mem_ready = 1'b0;
      e = base(3'd0); e.mr = 1'b1;
      step(e);
    end
    mem_ready = 1'b1;
    e = base(3'd0); e.mr = 1'b1; e.irw = 1'b1;
    step(e);
    mem_ready = 1'b0;
    step(base(3'd1));
    if (k == K_ILL) begin
      mIll = 1'b1;
      for (int i = 0; i < 3; i++) begin
        mem_ready = i[0];
        step(base(3'd7));
      end
      return;
    end

    e = base(3'd2);
    case (k)
      K_SUBU, K_BEQ: e.alu = 4'd1;
      K_SLT:         e.alu = 4'd6;
      K_ORI:         e.alu = 4'd2;
      K_LUI:         e.alu = 4'd3;
      K_ADDI:        e.alu = 4'd5;
      K_JR:          e.alu = 4'd4;
      default:       e.alu = 4'd0;
    endcase
    e.asrc = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW ||
              k == K_ADDI || k == K_ADDIU);
    if (k == K_LUI) e.ext = 2'b10;
    else if (k == K_LW || k == K_SW || k == K_ADDI || k == K_ADDIU || k == K_BEQ) e.ext = 2'b01;
    case (k)
      K_BEQ: begin e.pcw = 1'b1; e.npc = z ? 3'b001 : 3'b000; end
      K_J:   begin e.pcw = 1'b1; e.npc = 3'b011; end
      K_JR:  begin e.pcw = 1'b1; e.npc = 3'b100; end
      K_JAL: begin e.pcw = 1'b1; e.npc = 3'b010; e.rw = 1'b1; e.rdst = 2'b10; e.wd = 2'b10; end
      default: ;
    endcase
    step(e);
    if (e.pcw) return;

    if (k == K_LW || k == K_SW) begin
      if (memNever) begin
        for (int i = 0; i < 15; i++) begin
          if (i == abortAt) return;
          e = base(3'd3); e.mr = (k == K_LW); e.mw = (k == K_SW);
          step(e);
        end
        mBerr = 1'b1;
        step(base(3'd7));
        mem_ready = 1'b1;
        step(base(3'd7));
        mem_ready = 1'b0;
        return;
      end
      for (int i = 0; i <= memWait; i++) begin
        mem_ready = (i == memWait);
        e = base(3'd3); e.mr = (k == K_LW); e.mw = (k == K_SW);
        if (k == K_SW && i == memWait) e.pcw = 1'b1;
        step(e);
      end
      mem_ready = 1'b0;
      if (k == K_SW) return;
    end

    e = base(3'd4);
    e.pcw  = 1'b1;
    e.trap = (k == K_ADDI) && o;
    e.rw   = !e.trap;
    e.rdst = (op == 6'b000000) ? 2'b01 : 2'b00;
    e.wd   = (k == K_LW) ? 2'b01 : 2'b00;
    step(e);
  endtask

  initial begin
    tests = 0; fails = 0;
    mIll = 1'b0; mBerr = 1'b0; mInstret = '0;
    opcode = '0; funct = '0; zero = 1'b0; ovf = 1'b0; mem_ready = 1'b0;
    rst = 1'b0;
    doReset();

    runInstr(6'b000000, 6'b100001, 0, 0, 2, 0, 0, -1);     // addu
    chk("instret_after_addu", 64'(instret), 64'd1);
    runInstr(6'b000000, 6'b100011, 0, 0, 0, 0, 0, -1);     // subu
    runInstr(6'b000000, 6'b101010, 0, 0, 1, 0, 0, -1);     // slt
    runInstr(6'b001101, 6'b000000, 0, 0, 0, 0, 0, -1);     // ori
    runInstr(6'b001111, 6'b111111, 0, 0, 0, 0, 0, -1);     // lui
    runInstr(6'b001001, 6'b000000, 0, 1, 0, 0, 0, -1);     // addiu, ovf ignored
    runInstr(6'b000000, 6'b100001, 0, 1, 0, 0, 0, -1);     // addu, ovf ignored
    runInstr(6'b001000, 6'b000000, 0, 0, 0, 0, 0, -1);     // addi no ovf
    runInstr(6'b001000, 6'b000000, 0, 1, 0, 0, 0, -1);     // addi ovf trap
    chk("instret_after_9", 64'(instret), 64'd9);
    runInstr(6'b000100, 6'b000000, 1, 0, 0, 0, 0, -1);     // beq taken
    runInstr(6'b000100, 6'b000000, 0, 0, 0, 0, 0, -1);     // beq not taken
    runInstr(6'b000010, 6'b000000, 0, 0, 0, 0, 0, -1);     // j
    runInstr(6'b000011, 6'b000000, 0, 0, 0, 0, 0, -1);     // jal
    runInstr(6'b000000, 6'b001000, 0, 0, 0, 0, 0, -1);     // jr
    chk("instret_after_jumps", 64'(instret), 64'd14);
    runInstr(6'b100011, 6'b000000, 0, 0, 0, 3, 0, -1);     // lw, 3 wait cycles
    runInstr(6'b100011, 6'b000000, 0, 0, 0, 0, 0, -1);     // lw, immediate
    runInstr(6'b101011, 6'b000000, 0, 0, 0, 2, 0, -1);     // sw, 2 waits
    runInstr(6'b100011, 6'b000000, 0, 0, 0, 14, 0, -1);    // lw, ready on last chance
    chk("bus_err_after_late_ready", 64'(bus_err), 64'd0);

    runInstr(6'b101011, 6'b000000, 0, 0, 0, 0, 1, 5);      // sw, reset mid-MEM
    doReset();
    chk("instret_after_mid_mem_reset", 64'(instret), 64'd0);

    runInstr(6'b101011, 6'b000000, 0, 0, 0, 0, 1, -1);     // sw timeout
    chk("timeout_bus_err", 64'(bus_err), 64'd1);
    chk("timeout_state", 64'(state), 64'd7);
    doReset();

    runInstr(6'b111111, 6'b000000, 0, 0, 0, 0, 0, -1);     // illegal opcode
    chk("illegal_flag", 64'(illegal), 64'd1);
    chk("illegal_state", 64'(state), 64'd7);
    doReset();
    chk("illegal_cleared", 64'(illegal), 64'd0);
    runInstr(6'b000000, 6'b000000, 0, 0, 0, 0, 0, -1);     // illegal funct
    doReset();
    runInstr(6'b000000, 6'b100001, 0, 0, 0, 0, 0, -1);     // addu after recovery
    chk("instret_after_recovery", 64'(instret), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameters:
- ALU_W, default 4, AluCtrl width (codes zero-extended to ALU_W).
- TMO_W, default 4, memory-wait timeout counter width.
- CNT_W, default 32, retired-instruction counter width.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- opcode  in  6  IR[31:26], stable from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- ovf  in  1  ALU signed-add overflow.
- mem_ready  in  1  memory completes the current access this cycle.
- PcWrite, IrWrite, RegWrite, MemWrite, MemRead  out  1 each  write/read strobes.
- AluSrc  out  1  immediate operand select.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- wd_sel  out  2  00 ALU, 01 memory, 10 PC+4.
- NpcSel  out  3  000 PC+4, 001 branch, 010 jal, 011 j, 100 jr.
- ExtOp  out  2  00 zero-extend, 01 sign-extend, 10 lui shift.
- AluCtrl  out  ALU_W  Addu=0, Subu=1, Or=2, Bb=3, Aa=4, Add=5, Lt=6.
- state  out  3  current FSM state.
- illegal, bus_err  out  1 each  sticky fault flags.
- ovf_trap  out  1  one-cycle overflow pulse.
- instret  out  CNT_W  retired-instruction count.

Function
REQ-003 Supported instructions:
- R-type (opcode 000000) with funct addu 100001, subu 100011, slt 101010, jr 001000.
- ori 001101, lui 001111, lw 100011, sw 101011, addi 001000, addiu 001001, beq 000100, j 000010, jal 000011.
- Any other opcode/funct combination is illegal.
REQ-004 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7; state register updates on rising clk only.
REQ-005 Default: every output strobe is 0 and every select is 0 unless a requirement below asserts it.
REQ-006 FETCH: MemRead=1. When mem_ready=1: IrWrite=1, next state DECODE. Otherwise stay in FETCH; there is no timeout in FETCH.
REQ-007 DECODE: no strobes. Illegal instruction: set illegal, next state HALT. Otherwise next state EXEC.
REQ-008 EXEC drives AluCtrl, AluSrc and ExtOp per instruction:
- addu/addiu: Addu. subu/beq: Subu. slt: Lt. ori: Or. lui: Bb. addi: Add. jr: Aa.
- AluSrc=1 for ori, lui, lw, sw, addi, addiu.
- ExtOp=01 for lw, sw, addi, addiu, beq; ExtOp=10 for lui.
REQ-009 EXEC, control transfers (each goes to FETCH with PcWrite=1):
- beq: NpcSel=001 if zero=1, else 000.
- j: NpcSel=011.
- jr: NpcSel=100.
- jal: NpcSel=010, plus RegWrite=1, RegDst=10, wd_sel=10.
REQ-010 EXEC, other paths: lw/sw next state MEM; all remaining legal instructions next state WB.
REQ-011 MEM access: lw drives MemRead=1, sw drives MemWrite=1, with AluCtrl=Addu held throughout.
REQ-012 MEM completion: on mem_ready=1, sw goes to FETCH with PcWrite=1, NpcSel=000; lw goes to WB.
REQ-013 MEM timeout: a TMO_W-bit counter clears on MEM entry and increments each cycle with mem_ready=0. On reaching all-ones with mem_ready=0, set bus_err and go to HALT. mem_ready=1 in that same cycle completes normally.
REQ-014 WB common: PcWrite=1, NpcSel=000, next state FETCH.
REQ-015 WB register write: RegWrite=1. RegDst=01 for R-type, else 00. wd_sel=01 for lw, else 00.
REQ-016 WB overflow: addi with ovf=1 forces RegWrite=0, pulses ovf_trap for one cycle, and still advances the PC. Overflow on addu/addiu/subu is ignored.
REQ-017 instret increments by 1 (mod 2^CNT_W, wrapping to 0) on every cycle in which PcWrite=1.
REQ-018 HALT: all strobes 0, and the state remains HALT until reset.
REQ-019 All outputs are combinational from state and the inputs; only state, the counters and the fault flags are registered.

Reset
REQ-020 rst=0 asynchronously forces: state=FETCH, timeout counter=0, instret=0, illegal=0, bus_err=0. It applies at any time, including mid-MEM.
REQ-021 While rst=0, all write strobes (PcWrite, IrWrite, RegWrite, MemWrite) are 0. MemRead=1 from FETCH; no fetch completes until rst=1.

Verification
REQ-022 Reset release, then addu fetched with mem_ready=1 -> states 0,1,2,4,0. In WB: RegWrite=1, RegDst=01. instret=1.
REQ-023 beq with zero=1, then zero=0 -> EXEC PcWrite=1 with NpcSel=001, then 000. No RegWrite in either.
REQ-024 lw with mem_ready low 3 cycles in MEM -> MemRead held 4 cycles, then WB with wd_sel=01, RegWrite=1.
REQ-025 sw, mem_ready never asserted, TMO_W=4 -> 15 MEM cycles with MemWrite=1, then bus_err=1, state=7.
REQ-026 addi with ovf=1 -> WB RegWrite=0, ovf_trap=1 for one cycle, PcWrite=1.
REQ-027 opcode 111111 -> illegal=1, HALT. Asserting rst mid-HALT -> state 0, illegal 0.
